// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_updown_counter
//  Function : DIGITS-digit cascaded BCD up/down counter with clear, clamped
//             load, terminal-count flag and registered wrap carry pulse.
//             Define BCD_UPDOWN_COUNTER_SATURATE_EN to saturate at the limits.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter #(
   parameter int DIGITS = 4
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic                  Clear_In,
   input  logic                  Load_In,
   input  logic [4*DIGITS-1:0]   Load_Value_In,
   input  logic                  Enable_In,
   input  logic                  Up_Downb_In,
   output logic [4*DIGITS-1:0]   Count_Out,
   output logic                  Terminal_Out,
   output logic                  Carry_Out
);

   localparam logic [3:0] c_NINE = 4'd9;

   logic [4*DIGITS-1:0] r_count;
   logic                r_carry;
   logic [4*DIGITS-1:0] w_next;
   logic [4*DIGITS-1:0] w_load;
   logic [DIGITS-1:0]   w_is9;
   logic [DIGITS-1:0]   w_is0;
   logic [DIGITS:0]     w_run9;
   logic [DIGITS:0]     w_run0;
   logic                w_terminal;

   assign w_run9[0] = 1'b1;
   assign w_run0[0] = 1'b1;

   // w_run9[k]/w_run0[k]: every digit below k is 9 / 0, i.e. digit k steps.
   genvar k;
   generate
      for (k = 0; k < DIGITS; k++) begin : g_digit
         logic [3:0] w_cur;
         logic [3:0] w_ldv;
         logic       w_step;

         assign w_cur          = r_count[4*k +: 4];
         assign w_ldv          = Load_Value_In[4*k +: 4];
         assign w_is9[k]       = (w_cur == c_NINE);
         assign w_is0[k]       = (w_cur == 4'd0);
         assign w_run9[k+1]    = w_run9[k] & w_is9[k];
         assign w_run0[k+1]    = w_run0[k] & w_is0[k];
         assign w_step         = Up_Downb_In ? w_run9[k] : w_run0[k];
         assign w_load[4*k +: 4] = (w_ldv > c_NINE) ? c_NINE : w_ldv;

         always_comb begin
            w_next[4*k +: 4] = w_cur;
            if (w_step) begin
               if (Up_Downb_In)
                  w_next[4*k +: 4] = w_is9[k] ? 4'd0 : (w_cur + 4'd1);
               else
                  w_next[4*k +: 4] = w_is0[k] ? c_NINE : (w_cur - 4'd1);
            end
         end
      end
   endgenerate

   assign w_terminal = Up_Downb_In ? w_run9[DIGITS] : w_run0[DIGITS];

   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         r_count <= '0;
         r_carry <= 1'b0;
      end else if (Clear_In) begin
         r_count <= '0;
         r_carry <= 1'b0;
      end else if (Load_In) begin
         r_count <= w_load;
         r_carry <= 1'b0;
      end else if (Enable_In) begin
         // At the terminal count an enabled step is either a wrap or a blocked step.
         r_carry <= w_terminal;
`ifdef BCD_UPDOWN_COUNTER_SATURATE_EN
         if (!w_terminal)
            r_count <= w_next;
`else
         r_count <= w_next;
`endif
      end else begin
         r_carry <= 1'b0;
      end
   end

   assign Count_Out    = r_count;
   assign Carry_Out    = r_carry;
   assign Terminal_Out = w_terminal;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// Self-checking bench for bcd_updown_counter (DIGITS=2): integer reference
// model compared every cycle, plus directed literal expectations.
module tb_bcd_updown_counter;

   localparam int DIGITS = 2;
   localparam int MAXV   = 99;

   logic                Clk_In = 1'b0;
   logic                Reset_In;
   logic                Clear_In;
   logic                Load_In;
   logic [4*DIGITS-1:0] Load_Value_In;
   logic                Enable_In;
   logic                Up_Downb_In;
   logic [4*DIGITS-1:0] Count_Out;
   logic                Terminal_Out;
   logic                Carry_Out;

   int checks = 0;
   int errors = 0;

   int m_val   = 0;
   bit m_carry = 1'b0;

   bcd_updown_counter #(.DIGITS(DIGITS)) dut (
      .Clk_In        (Clk_In),
      .Reset_In      (Reset_In),
      .Clear_In      (Clear_In),
      .Load_In       (Load_In),
      .Load_Value_In (Load_Value_In),
      .Enable_In     (Enable_In),
      .Up_Downb_In   (Up_Downb_In),
      .Count_Out     (Count_Out),
      .Terminal_Out  (Terminal_Out),
      .Carry_Out     (Carry_Out)
   );

   always #5 Clk_In = ~Clk_In;

   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int clamp_val(input logic [4*DIGITS-1:0] v);
      int s, p, d;
      s = 0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         s = s + d * p;
         p = p * 10;
      end
      return s;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model in plain integer arithmetic.
   always @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         m_val   <= 0;
         m_carry <= 1'b0;
      end else if (Clear_In) begin
         m_val   <= 0;
         m_carry <= 1'b0;
      end else if (Load_In) begin
         m_val   <= clamp_val(Load_Value_In);
         m_carry <= 1'b0;
      end else if (Enable_In) begin
         if (Up_Downb_In) begin
            m_carry <= (m_val == MAXV);
`ifdef BCD_UPDOWN_COUNTER_SATURATE_EN
            if (m_val != MAXV) m_val <= m_val + 1;
`else
            m_val <= (m_val + 1) % (MAXV + 1);
`endif
         end else begin
            m_carry <= (m_val == 0);
`ifdef BCD_UPDOWN_COUNTER_SATURATE_EN
            if (m_val != 0) m_val <= m_val - 1;
`else
            m_val <= (m_val == 0) ? MAXV : m_val - 1;
`endif
         end
      end else begin
         m_carry <= 1'b0;
      end
   end

   always @(negedge Clk_In) begin
      check("model_count", int'(Count_Out), int'(to_bcd(m_val)));
      check("model_carry", int'(Carry_Out), int'(m_carry));
      check("model_term", int'(Terminal_Out),
            int'(Up_Downb_In ? (m_val == MAXV) : (m_val == 0)));
   end

   task automatic tick();
      @(posedge Clk_In);
      #2;
   endtask

   task automatic drive(input bit clr, input bit ld, input logic [7:0] val,
                        input bit en, input bit up);
      Clear_In      = clr;
      Load_In       = ld;
      Load_Value_In = val;
      Enable_In     = en;
      Up_Downb_In   = up;
   endtask

   int pulses;

   initial begin
      Reset_In = 1'b1;
      drive(0, 0, 8'h00, 0, 1);
      #1;
      check("reset_count", int'(Count_Out), 0);
      check("reset_carry", int'(Carry_Out), 0);
      tick();
      tick();
      Reset_In = 1'b0;

      // Up for 100 edges: 00..99 then 00, one carry on the wrap.
      drive(0, 0, 8'h00, 1, 1);
      pulses = 0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (Carry_Out) pulses++;
         if (i == 99) begin
            check("up_at_99", int'(Count_Out), 'h99);
            check("term_at_99", int'(Terminal_Out), 1);
            check("carry_before_wrap", int'(Carry_Out), 0);
         end
      end
      check("up_wrap_count", int'(Count_Out), 'h00);
      check("up_wrap_carry", int'(Carry_Out), 1);
      check("up_pulses", pulses, 1);

      // Load 0x37, down 38 edges.
      drive(0, 1, 8'h37, 0, 0);
      tick();
      check("load_37", int'(Count_Out), 'h37);
      drive(0, 0, 8'h00, 1, 0);
      pulses = 0;
      for (int i = 1; i <= 38; i++) begin
         tick();
         if (Carry_Out) pulses++;
         if (i == 1)  check("down_first", int'(Count_Out), 'h36);
         if (i == 37) check("down_zero", int'(Count_Out), 'h00);
      end
      check("down_wrap_count", int'(Count_Out), 'h99);
      check("down_pulses", pulses, 1);

      // Invalid digit clamps to 9.
      drive(0, 1, 8'h5C, 0, 1);
      tick();
      check("load_clamp", int'(Count_Out), 'h59);
      drive(0, 0, 8'h00, 1, 1);
      tick();
      check("clamp_then_up", int'(Count_Out), 'h60);

      // Priority: clear > load > enable.
      drive(1, 1, 8'h73, 1, 1);
      tick();
      check("prio_clear", int'(Count_Out), 'h00);
      drive(0, 1, 8'h73, 1, 1);
      tick();
      check("prio_load", int'(Count_Out), 'h73);
      drive(0, 0, 8'h73, 0, 1);
      tick();
      check("hold", int'(Count_Out), 'h73);
      check("hold_carry", int'(Carry_Out), 0);

      // Asynchronous reset mid-count.
      drive(0, 1, 8'h42, 0, 1);
      tick();
      drive(0, 0, 8'h00, 1, 1);
      Reset_In = 1'b1;
      #1;
      check("async_reset", int'(Count_Out), 'h00);
      #1;
      Reset_In = 1'b0;
      tick();
      check("after_reset_up", int'(Count_Out), 'h01);

`ifdef BCD_UPDOWN_COUNTER_SATURATE_EN
      drive(0, 1, 8'h98, 0, 1);
      tick();
      drive(0, 0, 8'h00, 1, 1);
      tick();
      check("sat_e1", int'(Count_Out), 'h99);
      check("sat_c1", int'(Carry_Out), 0);
      tick();
      check("sat_e2", int'(Count_Out), 'h99);
      check("sat_c2", int'(Carry_Out), 1);
      tick();
      check("sat_e3", int'(Count_Out), 'h99);
      check("sat_c3", int'(Carry_Out), 1);
      drive(1, 0, 8'h00, 0, 0);
      tick();
      drive(0, 0, 8'h00, 1, 0);
      tick();
      check("sat_down_hold", int'(Count_Out), 'h00);
      check("sat_down_carry", int'(Carry_Out), 1);
`else
      drive(0, 0, 8'h00, 1, 0);
      tick();
      check("down_from_01", int'(Count_Out), 'h00);
      tick();
      check("down_wrap_again", int'(Count_Out), 'h99);
      check("down_wrap_carry", int'(Carry_Out), 1);
`endif

      drive(0, 0, 8'h00, 0, 1);
      tick();
      @(negedge Clk_In);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
